// File: rtl/hazard_ctrl_unit.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, EX redirects,
// data-memory wait states and freeze requests, plus event counters and a sticky timeout.
module hazard_ctrl_unit #(
  parameter int REDIRECT_CYCLES = 2,
  parameter int MEM_TIMEOUT     = 15,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             freeze_req,
  input  logic             err_clr,
  output logic             stall_pc,
  output logic             stall_sub_if,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_sub_mem,
  output logic             flush_sub_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_sub_mem,
  output logic             flush_mem,
  output logic [2:0]       state_o,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    REDIRECT = 3'd1,
    MEM_WAIT = 3'd2,
    HALT     = 3'd3
  } state_t;

  state_t     state, state_nxt;
  logic       pend, pend_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [1:0] rdr_pos, rdr_pos_nxt;
  logic       stall_all, stall_front, flush_front, flush_back, flush_bubble;
  logic       err_set, redirect_evt, load_use;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // Next-state and Mealy control decode
  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend;
    wait_nxt     = wait_cnt;
    rdr_pos_nxt  = rdr_pos;
    stall_all    = 1'b0;
    stall_front  = 1'b0;
    flush_front  = 1'b0;
    flush_back   = 1'b0;
    flush_bubble = 1'b0;
    err_set      = 1'b0;
    redirect_evt = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          stall_all = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd0;
          pend_nxt  = ex_redirect;
        end else if (ex_redirect) begin
          flush_front  = 1'b1;
          flush_back   = 1'b1;
          redirect_evt = 1'b1;
          rdr_pos_nxt  = 2'd0;
          if (REDIRECT_CYCLES > 1) begin
            state_nxt = REDIRECT;
          end else begin
            state_nxt = RUN;
          end
        end else if (load_use) begin
          stall_front  = 1'b1;
          flush_bubble = 1'b1;
        end else if (freeze_req) begin
          state_nxt = HALT;
        end else begin
          state_nxt = RUN;
        end
      end
      // EX holds a bubble here, so every other event is ignored
      REDIRECT: begin
        flush_front = 1'b1;
        if (int'(rdr_pos) >= REDIRECT_CYCLES - 2) begin
          state_nxt = RUN;
        end else begin
          rdr_pos_nxt = rdr_pos + 2'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          if (pend) begin
            flush_front  = 1'b1;
            flush_back   = 1'b1;
            redirect_evt = 1'b1;
            pend_nxt     = 1'b0;
            rdr_pos_nxt  = 2'd0;
            state_nxt    = (REDIRECT_CYCLES > 1) ? REDIRECT : RUN;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          stall_all = 1'b1;
          if (int'(wait_cnt) >= MEM_TIMEOUT - 1) begin
            err_set   = 1'b1;
            pend_nxt  = 1'b0;
            wait_nxt  = 8'd0;
            state_nxt = HALT;
          end else begin
            wait_nxt = wait_cnt + 8'd1;
          end
        end
      end
      HALT: begin
        stall_all = 1'b1;
        if (!freeze_req && !err_timeout) begin
          state_nxt = RUN;
        end else begin
          state_nxt = HALT;
        end
      end
      default: begin
        state_nxt = RUN;
        pend_nxt  = 1'b0;
      end
    endcase
  end

  assign stall_pc      = !rst && (stall_all || stall_front);
  assign stall_sub_if  = !rst && (stall_all || stall_front);
  assign stall_if      = !rst && (stall_all || stall_front);
  assign stall_id      = !rst && (stall_all || stall_front);
  assign stall_ex      = !rst && stall_all;
  assign stall_sub_mem = !rst && stall_all;
  assign flush_sub_if  = !rst && flush_front;
  assign flush_if      = !rst && flush_front;
  assign flush_id      = !rst && flush_back;
  assign flush_ex      = !rst && (flush_back || flush_bubble);
  assign flush_sub_mem = 1'b0;
  assign flush_mem     = !rst && stall_all;
  assign state_o       = state;

  // State, flags and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      pend         <= 1'b0;
      wait_cnt     <= 8'd0;
      rdr_pos      <= 2'd0;
      err_timeout  <= 1'b0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      wait_cnt <= wait_nxt;
      rdr_pos  <= rdr_pos_nxt;
      if (err_set) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
      if (stall_pc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect_evt && (redirect_cnt != {CNT_W{1'b1}})) begin
        redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: driver queues hand-computed expectations
// per cycle, a monitor samples mid-cycle and compares.
module tb_hazard_ctrl_unit;

  localparam int CW = 4;

  localparam logic [8:0] C_RST = 9'h100;
  localparam logic [8:0] C_U1  = 9'h080;
  localparam logic [8:0] C_U2  = 9'h040;
  localparam logic [8:0] C_LD  = 9'h020;
  localparam logic [8:0] C_RD  = 9'h010;
  localparam logic [8:0] C_MQ  = 9'h008;
  localparam logic [8:0] C_MR  = 9'h004;
  localparam logic [8:0] C_FZ  = 9'h002;
  localparam logic [8:0] C_EC  = 9'h001;
  localparam logic [8:0] C_0   = 9'h000;

  // stall order {pc,sub_if,if,id,ex,sub_mem}; flush order {sub_if,if,id,ex,sub_mem,mem}
  localparam logic [5:0] S0   = 6'b000000;
  localparam logic [5:0] S4   = 6'b111100;
  localparam logic [5:0] SALL = 6'b111111;
  localparam logic [5:0] F0   = 6'b000000;
  localparam logic [5:0] FR0  = 6'b111100;
  localparam logic [5:0] FR1  = 6'b110000;
  localparam logic [5:0] FEX  = 6'b000100;
  localparam logic [5:0] FMEM = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_is_load, ex_redirect;
  logic mem_req, mem_ready, freeze_req, err_clr;
  logic stall_pc, stall_sub_if, stall_if, stall_id, stall_ex, stall_sub_mem;
  logic flush_sub_if, flush_if, flush_id, flush_ex, flush_sub_mem, flush_mem;
  logic [2:0] state_o;
  logic err_timeout;
  logic [CW-1:0] stall_cnt, redirect_cnt;

  typedef struct {
    string      nm;
    logic [5:0] s;
    logic [5:0] f;
    logic [2:0] st;
    logic       e;
    int         sc;
    int         rc;
  } exp_t;

  exp_t q[$];
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .REDIRECT_CYCLES(2),
    .MEM_TIMEOUT(4),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_req(freeze_req), .err_clr(err_clr),
    .stall_pc(stall_pc), .stall_sub_if(stall_sub_if), .stall_if(stall_if),
    .stall_id(stall_id), .stall_ex(stall_ex), .stall_sub_mem(stall_sub_mem),
    .flush_sub_if(flush_sub_if), .flush_if(flush_if), .flush_id(flush_id),
    .flush_ex(flush_ex), .flush_sub_mem(flush_sub_mem), .flush_mem(flush_mem),
    .state_o(state_o), .err_timeout(err_timeout),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  // One cycle of stimulus, applied on the falling edge, with its expected response
  task automatic cyc(input string nm, input logic [8:0] c,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic [5:0] es, input logic [5:0] ef, input logic [2:0] est,
                     input logic ee, input int esc, input int erc);
    exp_t x;
    @(negedge clk);
    rst         = c[8];
    id_rs1_used = c[7];
    id_rs2_used = c[6];
    ex_is_load  = c[5];
    ex_redirect = c[4];
    mem_req     = c[3];
    mem_ready   = c[2];
    freeze_req  = c[1];
    err_clr     = c[0];
    id_rs1      = r1;
    id_rs2      = r2;
    ex_rd       = rd;
    x.nm = nm; x.s = es; x.f = ef; x.st = est; x.e = ee; x.sc = esc; x.rc = erc;
    q.push_back(x);
  endtask

  // Monitor: outputs are valid every cycle once inputs settle after the falling edge
  initial begin
    exp_t m;
    logic [5:0] as, af;
    logic [CW-1:0] esc, erc;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        m  = q.pop_front();
        as = {stall_pc, stall_sub_if, stall_if, stall_id, stall_ex, stall_sub_mem};
        af = {flush_sub_if, flush_if, flush_id, flush_ex, flush_sub_mem, flush_mem};
        esc = m.sc[CW-1:0];
        erc = m.rc[CW-1:0];
        n_vec++;
        if (as !== m.s || af !== m.f || state_o !== m.st || err_timeout !== m.e ||
            stall_cnt !== esc || redirect_cnt !== erc) begin
          n_miss++;
          $display("FAIL %s: got stall=%b flush=%b state=%0d err=%b scnt=%0d rcnt=%0d; want stall=%b flush=%b state=%0d err=%b scnt=%0d rcnt=%0d",
                   m.nm, as, af, state_o, err_timeout, stall_cnt, redirect_cnt,
                   m.s, m.f, m.st, m.e, esc, erc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; freeze_req = 1'b0; err_clr = 1'b0;

    cyc("reset",      C_RST,               5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 0, 0);
    cyc("idle",       C_0,                 5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 0, 0);
    // load-use hazards
    cyc("lu_rs1",     C_U1|C_LD,           5'd5, 5'd0, 5'd5, S4,   FEX,  3'd0, 1'b0, 0, 0);
    cyc("lu_after",   C_0,                 5'd5, 5'd0, 5'd5, S0,   F0,   3'd0, 1'b0, 1, 0);
    cyc("lu_rs2",     C_U2|C_LD,           5'd0, 5'd7, 5'd7, S4,   FEX,  3'd0, 1'b0, 1, 0);
    cyc("lu_rd0",     C_U1|C_LD,           5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 2, 0);
    cyc("lu_unused",  C_LD,                5'd5, 5'd0, 5'd5, S0,   F0,   3'd0, 1'b0, 2, 0);
    // redirect window, REDIRECT ignores everything else
    cyc("rdr0",       C_RD,                5'd0, 5'd0, 5'd0, S0,   FR0,  3'd0, 1'b0, 2, 0);
    cyc("rdr1",       C_RD|C_MQ|C_FZ|C_U1|C_LD, 5'd5, 5'd0, 5'd5, S0, FR1, 3'd1, 1'b0, 2, 1);
    cyc("rdr2",       C_0,                 5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 2, 1);
    // priority: redirect beats load-use and freeze
    cyc("prio",       C_U1|C_LD|C_RD|C_FZ, 5'd5, 5'd0, 5'd5, S0,   FR0,  3'd0, 1'b0, 2, 1);
    cyc("prio_r1",    C_0,                 5'd0, 5'd0, 5'd0, S0,   FR1,  3'd1, 1'b0, 2, 2);
    cyc("prio_r2",    C_0,                 5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 2, 2);
    // memory wait with pending redirect
    cyc("mw0",        C_MQ|C_RD,           5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd0, 1'b0, 2, 2);
    cyc("mw1",        C_0,                 5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd2, 1'b0, 3, 2);
    cyc("mw2",        C_0,                 5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd2, 1'b0, 4, 2);
    cyc("mw3",        C_0,                 5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd2, 1'b0, 5, 2);
    cyc("mw_rdy",     C_MR,                5'd0, 5'd0, 5'd0, S0,   FR0,  3'd2, 1'b0, 6, 2);
    cyc("mw_r1",      C_0,                 5'd0, 5'd0, 5'd0, S0,   FR1,  3'd1, 1'b0, 6, 3);
    cyc("mw_r2",      C_0,                 5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 6, 3);
    // plain memory wait, stray and same-cycle ready
    cyc("mq",         C_MQ,                5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd0, 1'b0, 6, 3);
    cyc("mq_rdy",     C_MR,                5'd0, 5'd0, 5'd0, S0,   F0,   3'd2, 1'b0, 7, 3);
    cyc("mr_stray",   C_MR,                5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 7, 3);
    cyc("mq_hit",     C_MQ|C_MR,           5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 7, 3);
    // timeout after four waiting cycles
    cyc("to0",        C_MQ,                5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd0, 1'b0, 7, 3);
    cyc("to1",        C_MQ,                5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd2, 1'b0, 8, 3);
    cyc("to2",        C_MQ,                5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd2, 1'b0, 9, 3);
    cyc("to3",        C_MQ,                5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd2, 1'b0, 10, 3);
    cyc("to4",        C_MQ,                5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd2, 1'b0, 11, 3);
    cyc("halt_a",     C_FZ,                5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd3, 1'b1, 12, 3);
    cyc("halt_b",     C_0,                 5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd3, 1'b1, 13, 3);
    cyc("errclr",     C_EC,                5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd3, 1'b1, 14, 3);
    cyc("halt_exit",  C_0,                 5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd3, 1'b0, 15, 3);
    cyc("run_sat",    C_0,                 5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 15, 3);
    // freeze entry/exit, stall counter held at saturation
    cyc("frz",        C_FZ,                5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 15, 3);
    cyc("frz_h",      C_FZ,                5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd3, 1'b0, 15, 3);
    cyc("frz_rel",    C_0,                 5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd3, 1'b0, 15, 3);
    cyc("frz_done",   C_0,                 5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 15, 3);
    // asynchronous reset in MEM_WAIT loses the pending redirect
    cyc("ar0",        C_MQ|C_RD,           5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd0, 1'b0, 15, 3);
    cyc("ar1",        C_0,                 5'd0, 5'd0, 5'd0, SALL, FMEM, 3'd2, 1'b0, 15, 3);
    cyc("async_rst",  C_RST|C_MQ,          5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 0, 0);
    cyc("post_rst",   C_MR,                5'd0, 5'd0, 5'd0, S0,   F0,   3'd0, 1'b0, 0, 0);
    cyc("post_rdr0",  C_RD,                5'd0, 5'd0, 5'd0, S0,   FR0,  3'd0, 1'b0, 0, 0);
    cyc("post_rdr1",  C_0,                 5'd0, 5'd0, 5'd0, S0,   FR1,  3'd1, 1'b0, 0, 1);

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    #5;
    if (q.size() > 0) begin
      n_miss += q.size();
      $display("FAIL drain: %0d vectors still pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Central stall/flush sequencer for the five-stage fetch/decode/execute/memory/writeback pipeline, including its sub-IF and sub-MEM registers. It detects load-use hazards, taken control transfers resolved in EX, data-memory wait states and external freeze requests. From these it drives the per-stage stall_* and flush_* controls that the pipeline registers consume. It also keeps saturating performance counters and a sticky memory-timeout error.

## Interface
- REDIRECT_CYCLES, 2: total flush cycles per taken redirect; legal range 1..4. The extra cycles cover the one-cycle instruction BRAM read latency.
- MEM_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before the timeout error is raised; legal range 1..255.
- CNT_W, 16: width of the performance counters.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1 each  the corresponding source is actually read.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_is_load  in  1  the instruction in EX is a load.
- ex_redirect  in  1  a taken branch or jump is resolved in EX this cycle.
- mem_req  in  1  EX is issuing a data-memory access this cycle.
- mem_ready  in  1  data memory completes the outstanding access.
- freeze_req  in  1  debug/external halt request, level-sensitive.
- err_clr  in  1  clears err_timeout.
- stall_pc, stall_sub_if, stall_if, stall_id, stall_ex, stall_sub_mem  out  1 each  hold the corresponding register.
- flush_sub_if, flush_if, flush_id, flush_ex, flush_sub_mem, flush_mem  out  1 each  zero the corresponding register.
- state_o  out  3  current state: RUN=0, REDIRECT=1, MEM_WAIT=2, HALT=3.
- err_timeout  out  1  sticky memory-timeout flag.
- stall_cnt, redirect_cnt  out  CNT_W each  saturating event counters.

## Operation
- Outputs are Mealy: stall_* and flush_* are combinational from the registered state and the current inputs. State, counters and flags are registered.
- Load-use hazard: ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- RUN evaluates events in priority order, highest first:
  1. **Memory wait** (mem_req & ~mem_ready):
     - assert all six stall_* and flush_mem;
     - next state MEM_WAIT, wait counter cleared;
     - if ex_redirect is also high, set pending_redirect.
  2. **Redirect** (ex_redirect):
     - assert flush_sub_if, flush_if, flush_id, flush_ex; redirect_cnt increments;
     - next state REDIRECT if REDIRECT_CYCLES>1, else remain in RUN.
  3. **Load-use:** assert stall_pc, stall_sub_if, stall_if, stall_id and flush_ex for one cycle (bubble inserted into EX). No state change.
  4. **Freeze** (freeze_req): no outputs this cycle; next state HALT.
- REDIRECT:
  - asserts flush_sub_if and flush_if only;
  - stays REDIRECT_CYCLES-1 cycles, then returns to RUN;
  - ignores mem_req, hazards, freeze and any new ex_redirect (EX is a bubble).
- MEM_WAIT:
  - while ~mem_ready: all stall_* and flush_mem asserted; wait counter increments each cycle.
  - On mem_ready: no stall this cycle. If pending_redirect is set, apply the redirect-cycle-0 flushes, clear pending_redirect, count it, and go to REDIRECT or RUN. Otherwise go to RUN.
  - If the wait counter reaches MEM_TIMEOUT without mem_ready: set err_timeout, go to HALT, clear pending_redirect.
- HALT:
  - all stall_* and flush_mem asserted;
  - exits to RUN when freeze_req==0 and err_timeout==0;
  - err_clr clears err_timeout in any state, taking effect on the next cycle.
- stall_cnt increments on every cycle stall_pc is 1. Both counters saturate at all-ones and never wrap.
- flush_sub_mem is never asserted. It is reserved and tied to 0.

## Timing
- Reset values:
  - state RUN, pending_redirect 0, wait counter 0;
  - stall_cnt 0, redirect_cnt 0, err_timeout 0;
  - every stall_* and flush_* output forced to 0 while rst is high.
- Zero-cycle latency from inputs to stall_*/flush_* in the same cycle. State transitions take effect at the next rising edge.
- Redirect flush window: exactly REDIRECT_CYCLES consecutive cycles with flush_if=1.
- Timeout: err_timeout rises on the edge after the MEM_TIMEOUT-th consecutive waiting cycle.
- Reset mid-operation: immediate, asynchronous return to the reset values. Any pending redirect is lost.
- mem_ready while not in MEM_WAIT and not accompanied by mem_req: ignored.

## Test plan
- **Load-use:** ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle -> stall_pc/sub_if/if/id=1 and flush_ex=1 that cycle only; state_o stays 0; stall_cnt=1.
- **Redirect, REDIRECT_CYCLES=2:** ex_redirect pulse -> cycle 0: flush_sub_if/if/id/ex=1; cycle 1: state_o=1 with flush_sub_if/if=1 only; cycle 2: all flushes 0; redirect_cnt=1.
- **Memory wait with redirect:** mem_req=1 with ex_redirect=1, then mem_ready=1 after 3 cycles:
  - 4 cycles of stalls, state_o=2;
  - the ready cycle has no stall, flush_if=1, then REDIRECT;
  - stall_cnt=4, redirect_cnt=1.
- **Timeout, MEM_TIMEOUT=4:** mem_req=1 and mem_ready held 0 -> err_timeout=1 after 4 wait cycles, state_o=3. Dropping freeze_req keeps HALT; an err_clr pulse returns to RUN one cycle later.
- **Priority:** load-use hazard, ex_redirect and freeze_req all high together -> only the redirect flushes occur, no stall, next state REDIRECT.
- **Async reset:** rst asserted mid-MEM_WAIT -> state_o=0, outputs 0 and counters 0 before the next clock edge.
